// File: rtl/vqueue_fifo_pkg.sv
// Shared constants and helpers for the vqueue FIFO: default parameter values,
// derived depth/count widths and the read-mode encoding.
package vqueue_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_AE_LEVEL   = 32;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  function automatic int depth_of(input int aw);
    return 2 ** aw;
  endfunction

  function automatic int cnt_w_of(input int aw);
    return aw + 1;
  endfunction

  function automatic int default_af_level(input int aw);
    return depth_of(aw) - 32;
  endfunction

endpackage

// File: rtl/vqueue_fifo_bram.sv
// Simple dual-port RAM on one clock: write port A, registered read port B with
// read enable and synchronous clear of the read register. No write-to-read bypass.
module bram_sdp_1clk #(
  parameter int data_width = 32,
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem_r [0:(2**addr_width)-1];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; only rst clears it so a flush leaves the last word visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= {data_width{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/vqueue_fifo.sv
// Single-clock FIFO with programmable almost flags, occupancy count, sticky
// error flags, flush, and standard or first-word-fall-through read mode.
module vqueue_fifo
  import vqueue_fifo_pkg::*;
#(
  parameter int data_width         = DEF_DATA_WIDTH,
  parameter int addr_width         = DEF_ADDR_WIDTH,
  parameter int almost_empty_level = DEF_AE_LEVEL,
  parameter int almost_full_level  = default_af_level(addr_width),
  parameter int fwft               = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [data_width-1:0] data,
  input  logic                  rd_en,
  output logic [data_width-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int       DEPTH = depth_of(addr_width);
  localparam int       CNT_W = cnt_w_of(addr_width);
  localparam rd_mode_e MODE  = (fwft != 0) ? RD_FWFT : RD_STANDARD;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(almost_empty_level);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(almost_full_level);

  logic [CNT_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_r;
  logic             full_r;
  logic             ae_r;
  logic             af_r;
  logic             ovf_r;
  logic             unf_r;
  logic             ov_r;

  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             fetch_s;
  logic             ov_nxt_s;
  logic             empty_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             ram_we_s;
  logic             ram_re_s;
  logic [data_width-1:0] ram_q_s;

  // Accept decisions, RAM fetch and next-state occupancy.
  // In FWFT mode the RAM read register is the output stage; a fetch lands the
  // head word on q, so a pop with words left in RAM refills it on the same edge.
  always_comb begin
    wr_acc_s    = wr_en & ~full_r;
    rd_acc_s    = rd_en & ~empty_r;
    count_nxt_s = count_r + CNT_W'(wr_acc_s) - CNT_W'(rd_acc_s);
    if (MODE == RD_FWFT) begin
      fetch_s     = (wr_ptr_r != rd_ptr_r) & (~ov_r | rd_acc_s);
      ov_nxt_s    = fetch_s | (ov_r & ~rd_acc_s);
      empty_nxt_s = ~ov_nxt_s;
    end else begin
      fetch_s     = rd_acc_s;
      ov_nxt_s    = 1'b0;
      empty_nxt_s = (count_nxt_s == {CNT_W{1'b0}});
    end
    ram_we_s = wr_acc_s & rst & ~flush;
    ram_re_s = fetch_s & rst & ~flush;
  end

  // Pointers, count, flags and sticky errors; rst beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_r <= {CNT_W{1'b0}};
      rd_ptr_r <= {CNT_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ae_r     <= 1'b1;
      af_r     <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      ov_r     <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_r + CNT_W'(wr_acc_s);
      rd_ptr_r <= rd_ptr_r + CNT_W'(fetch_s);
      count_r  <= count_nxt_s;
      empty_r  <= empty_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_C);
      ae_r     <= (count_nxt_s < AE_C);
      af_r     <= (count_nxt_s >= AF_C);
      ovf_r    <= ovf_r | (wr_en & full_r);
      unf_r    <= unf_r | (rd_en & empty_r);
      ov_r     <= ov_nxt_s;
    end
  end

  bram_sdp_1clk #(
    .data_width (data_width),
    .addr_width (addr_width)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we_s),
    .wr_addr (wr_ptr_r[addr_width-1:0]),
    .wr_data (data),
    .rd_en   (ram_re_s),
    .rd_addr (rd_ptr_r[addr_width-1:0]),
    .rd_data (ram_q_s)
  );

  assign q            = ram_q_s;
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = ae_r;
  assign almost_full  = af_r;
  assign count        = count_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: doc/vqueue_fifo.md
Name: vqueue_fifo

Overview:
Single-clock, parametrised successor of the video-queue FIFO: configurable data width and depth, working full/almost-full flags with programmable thresholds, occupancy count, selectable standard or first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags. It sits between a DMA/RAM reader and a pixel or serial consumer running on the same clock. Storage is an inferred simple-dual-port block RAM.

Parameters:
data_width, 32, bits per word
addr_width, 11, log2 of depth; depth = 2**addr_width
almost_empty_level, 32, almost_empty asserted while count < this value
almost_full_level, 2**addr_width-32, almost_full asserted while count >= this value
fwft, 1, 1 = first-word-fall-through, 0 = standard registered read

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-low: 0 sampled at clk edge resets the block
flush  in  1  synchronous clear, active-high
wr_en  in  1  write request
data  in  data_width  write data
rd_en  in  1  read/pop request
q  out  data_width  read data
empty  out  1  no word available to consumer
full  out  1  no space for a write
almost_empty  out  1  count < almost_empty_level
almost_full  out  1  count >= almost_full_level
count  out  addr_width+1  words held, 0..depth
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Priority: rst=0 > flush=1 > wr/rd. All outputs are registered.
- Reset: pointers=0, count=0, q=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, FWFT output stage invalid.
- Flush: same as reset except q holds its value. wr_en/rd_en in the flush cycle are dropped and do not set the error flags.
- Pointers are addr_width+1 bits and wrap modulo 2*depth. The MSB distinguishes full from empty. count = wr_ptr - rd_ptr, plus 1 when the FWFT output stage holds a word.
- Write is accepted iff wr_en=1 and full=0, using the registered full of that cycle. A write while full is dropped and sets overflow. This applies even with a simultaneous read.
- Read is accepted iff rd_en=1 and empty=0. A read while empty is ignored and sets underflow. This applies even with a simultaneous write.
- A simultaneous accepted read and write leaves count unchanged.
- fwft=0: an accepted read drives rd_ptr to the RAM. q updates at the accepting edge, so data is visible in the next cycle (latency 1), and holds otherwise. empty deasserts at the edge after the first write into an empty FIFO.
- fwft=1: q shows the head word whenever empty=0. rd_en pops the word, and the next word (if any) appears on q at the same edge, so back-to-back pops are sustained at 1 word/cycle. Write-to-empty-deassert latency is 2 cycles: RAM fetch, then output stage load. The RAM never reads an address in the cycle it is written.
- full=1 exactly when count == depth. empty=1 exactly when no word is readable by the consumer.
- almost_empty and almost_full are derived from the next-state count, so they change in the same cycle as count.
- overflow and underflow stay at 1 until rst or flush.

Decomposition:
- Shared package/header holds the derived constants: DEPTH = 2**addr_width, CNT_W = addr_width+1, and default threshold values.
- One sub-module, bram_sdp_1clk: simple dual-port RAM, one clock, write port A, registered read port B with read enable, no pass-through.
- FIFO control, counters, flags and the FWFT output stage live in vqueue_fifo.

Test Plan:
- Bench configuration: addr_width=4, thresholds 4/12. Release reset, write 16 words 0x100..0x10F. Required: count steps 1..16; almost_empty falls at count=4; almost_full rises at count=12; full=1 at 16. A 17th write sets overflow=1 and count stays 16.
- fwft=1: from the full state, rd_en held for 16 cycles. Required: q=0x100..0x10F consecutively, empty=1 after the last pop. One extra rd_en sets underflow=1.
- fwft=0: write 0xA5 into an empty FIFO; empty=0 one cycle later. Pulse rd_en; q=0xA5 in the following cycle.
- Simultaneous wr_en and rd_en at count=8 for 40 cycles: count stays 8, data order is preserved across pointer wrap, no flags set.
- Simultaneous wr_en and rd_en when full: read accepted, write dropped, overflow=1, count=15. When empty: write accepted, underflow=1, count=1.
- Assert flush at count=10 with wr_en=1, then rst=0 mid-stream. Each must give count=0, empty=1, errors cleared. After flush q keeps its last value; after rst q=0.
